// File: rtl/machine_timer_pkg.sv
// machine_timer_pkg: shared constants and helpers for the machine timer.
//   - Register byte offsets inside the timer window.
//   - Reset value of mtimecmp.
//   - Register-select enum plus decode and byte-enable merge helpers.
package machine_timer_pkg;

  localparam int unsigned MTIMER_MTIME_LO    = 32'h00;
  localparam int unsigned MTIMER_MTIME_HI    = 32'h04;
  localparam int unsigned MTIMER_MTIMECMP_LO = 32'h08;
  localparam int unsigned MTIMER_MTIMECMP_HI = 32'h0C;
  localparam int unsigned MTIMER_MSIP        = 32'h10;

  localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic [2:0] {
    SEL_MTIME_LO,
    SEL_MTIME_HI,
    SEL_MTIMECMP_LO,
    SEL_MTIMECMP_HI,
    SEL_MSIP,
    SEL_NONE
  } reg_sel_e;

  // Word-aligned byte offset -> register select; unmapped offsets give SEL_NONE.
  function automatic reg_sel_e reg_decode(input logic [31:0] off);
    reg_sel_e sel;
    case (off)
      MTIMER_MTIME_LO:    sel = SEL_MTIME_LO;
      MTIMER_MTIME_HI:    sel = SEL_MTIME_HI;
      MTIMER_MTIMECMP_LO: sel = SEL_MTIMECMP_LO;
      MTIMER_MTIMECMP_HI: sel = SEL_MTIMECMP_HI;
      MTIMER_MSIP:        sel = SEL_MSIP;
      default:            sel = SEL_NONE;
    endcase
    return sel;
  endfunction

  // Replace the bytes of old_val selected by be with those of new_val.
  function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                           input logic [31:0] new_val,
                                           input logic [3:0]  be);
    logic [31:0] res;
    for (int unsigned i = 0; i < 4; i++) begin
      res[8*i +: 8] = be[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/machine_timer_if.sv
// machine_timer_if: single-outstanding request/response data-bus port.
//   req_i    request pulse, one per access
//   we_i     1 = write, 0 = read
//   addr_i   byte address (bits [1:0] ignored by the slave)
//   be_i     write byte enables
//   wdata_i  write data
//   gnt_o    request accepted (slave is always ready)
//   rvalid_o response valid, one cycle after the request
//   rdata_o  read data, valid with rvalid_o
// Signal suffixes are named from the slave's point of view.
interface machine_timer_if #(
  parameter int unsigned ADDR_W = 5
) ();
  logic              req_i;
  logic              we_i;
  logic [ADDR_W-1:0] addr_i;
  logic [3:0]        be_i;
  logic [31:0]       wdata_i;
  logic              gnt_o;
  logic              rvalid_o;
  logic [31:0]       rdata_o;

  modport master (
    output req_i, we_i, addr_i, be_i, wdata_i,
    input  gnt_o, rvalid_o, rdata_o
  );

  modport slave (
    input  req_i, we_i, addr_i, be_i, wdata_i,
    output gnt_o, rvalid_o, rdata_o
  );
endinterface

// File: rtl/machine_timer_prescaler_tick.sv
// prescaler_tick: divides clk_i into a one-cycle tick every PRESCALE cycles.
//   clk_i   clock
//   rst_i   synchronous active-high reset (counter back to 0)
//   tick_o  high in the cycle the counter sits at PRESCALE-1
// PRESCALE legal range is 1..65535; PRESCALE=1 ticks every cycle.
module prescaler_tick #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);
  localparam int unsigned        CNT_W = 16;
  localparam logic [CNT_W-1:0]   TERM  = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    tick_o = (cnt_q == TERM);
    cnt_d  = tick_o ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/machine_timer.sv
// machine_timer: memory-mapped machine timer and software-interrupt source.
//   clk_i          clock
//   rst_i          synchronous active-high reset
//   bus            machine_timer_if slave port (req/we/addr/be/wdata in,
//                  gnt/rvalid/rdata out), reads have one cycle of latency
//   irq_timer_o    level interrupt, registered (mtime >= mtimecmp)
//   irq_software_o level interrupt, registered copy of msip
// Registers: 64-bit mtime (advances on every prescaler tick), 64-bit mtimecmp,
// 1-bit msip. ADDR_W must be at least 5 to reach the MSIP word.
module machine_timer
  import machine_timer_pkg::*;
#(
  parameter int unsigned PRESCALE = 1,
  parameter int unsigned ADDR_W   = 5
) (
  input  logic            clk_i,
  input  logic            rst_i,
  machine_timer_if.slave  bus,
  output logic            irq_timer_o,
  output logic            irq_software_o
);
  logic        tick;
  logic        wr, rd;
  reg_sel_e    sel;

  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        msip_q, msip_d;
  logic        rvalid_q;
  logic [31:0] rdata_q, rdata_d;
  logic        irq_timer_q, irq_software_q;

  logic        unused_addr_bits;
  assign unused_addr_bits = ^bus.addr_i[1:0];

  prescaler_tick #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .tick_o (tick)
  );

  assign bus.gnt_o      = bus.req_i;
  assign bus.rvalid_o   = rvalid_q;
  assign bus.rdata_o    = rdata_q;
  assign irq_timer_o    = irq_timer_q;
  assign irq_software_o = irq_software_q;

  always_comb begin
    wr  = bus.req_i &  bus.we_i;
    rd  = bus.req_i & ~bus.we_i;
    sel = reg_decode(32'({bus.addr_i[ADDR_W-1:2], 2'b00}));

    mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;
    rdata_d    = rdata_q;

    // A write to either mtime half replaces the tick increment for that
    // cycle: the untouched half and unwritten bytes keep their old value.
    if (wr) begin
      case (sel)
        SEL_MTIME_LO:    mtime_d = {mtime_q[63:32],
                                    be_merge(mtime_q[31:0], bus.wdata_i, bus.be_i)};
        SEL_MTIME_HI:    mtime_d = {be_merge(mtime_q[63:32], bus.wdata_i, bus.be_i),
                                    mtime_q[31:0]};
        SEL_MTIMECMP_LO: mtimecmp_d[31:0]  = be_merge(mtimecmp_q[31:0], bus.wdata_i, bus.be_i);
        SEL_MTIMECMP_HI: mtimecmp_d[63:32] = be_merge(mtimecmp_q[63:32], bus.wdata_i, bus.be_i);
        SEL_MSIP:        if (bus.be_i[0]) msip_d = bus.wdata_i[0];
        default:         ;
      endcase
    end

    if (rd) begin
      case (sel)
        SEL_MTIME_LO:    rdata_d = mtime_q[31:0];
        SEL_MTIME_HI:    rdata_d = mtime_q[63:32];
        SEL_MTIMECMP_LO: rdata_d = mtimecmp_q[31:0];
        SEL_MTIMECMP_HI: rdata_d = mtimecmp_q[63:32];
        SEL_MSIP:        rdata_d = {31'b0, msip_q};
        default:         rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mtime_q        <= '0;
      mtimecmp_q     <= MTIMECMP_RST;
      msip_q         <= 1'b0;
      rvalid_q       <= 1'b0;
      rdata_q        <= '0;
      irq_timer_q    <= 1'b0;
      irq_software_q <= 1'b0;
    end else begin
      mtime_q        <= mtime_d;
      mtimecmp_q     <= mtimecmp_d;
      msip_q         <= msip_d;
      rvalid_q       <= bus.req_i;
      rdata_q        <= rdata_d;
      irq_timer_q    <= (mtime_q >= mtimecmp_q);
      irq_software_q <= msip_q;
    end
  end
endmodule

// File: tb/tb_machine_timer.sv
// tb_machine_timer: self-checking bench for machine_timer.
// Two instances share clock and reset: dut (PRESCALE=1) carries most tests,
// dut4 (PRESCALE=4) checks the prescaled count rate.
module tb_machine_timer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  machine_timer_if #(.ADDR_W(5)) b1 ();
  machine_timer_if #(.ADDR_W(5)) b4 ();

  logic irq_t1, irq_s1, irq_t4, irq_s4;

  machine_timer #(.PRESCALE(1), .ADDR_W(5)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .bus            (b1),
    .irq_timer_o    (irq_t1),
    .irq_software_o (irq_s1)
  );

  machine_timer #(.PRESCALE(4), .ADDR_W(5)) dut4 (
    .clk_i          (clk),
    .rst_i          (rst),
    .bus            (b4),
    .irq_timer_o    (irq_t4),
    .irq_software_o (irq_s4)
  );

  int tests = 0;
  int fails = 0;
  int rvalid_cnt = 0;

  typedef struct {
    logic        chk;
    logic [31:0] exp;
    string       name;
  } sb_t;
  sb_t sbq[$];

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp;
    string       name;
  } vec_t;
  vec_t vt[$];

  // Reference state of the PRESCALE=1 instance, advanced once per clock edge.
  logic [63:0] m_mtime;
  logic [63:0] m_cmp;
  logic        m_msip;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] tb_merge(input logic [31:0] o, input logic [31:0] n,
                                           input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = n[i*8 +: 8];
    return r;
  endfunction

  // One clock on the dut bus; entered and left at posedge+1.
  task automatic cycle(input logic rq, input logic w, input logic [4:0] a,
                       input logic [3:0] be, input logic [31:0] wd);
    logic        exp_t, exp_s;
    logic [63:0] nxt;
    sb_t         e;
    b1.req_i = rq; b1.we_i = w; b1.addr_i = a; b1.be_i = be; b1.wdata_i = wd;
    exp_t = (m_mtime >= m_cmp);
    exp_s = m_msip;
    nxt   = m_mtime + 64'd1;
    if (rq && w) begin
      case ({a[4:2], 2'b00})
        5'h00: nxt = {m_mtime[63:32], tb_merge(m_mtime[31:0], wd, be)};
        5'h04: nxt = {tb_merge(m_mtime[63:32], wd, be), m_mtime[31:0]};
        5'h08: m_cmp[31:0]  = tb_merge(m_cmp[31:0], wd, be);
        5'h0C: m_cmp[63:32] = tb_merge(m_cmp[63:32], wd, be);
        5'h10: if (be[0]) m_msip = wd[0];
        default: ;
      endcase
    end
    check("gnt", b1.gnt_o, rq);
    @(posedge clk); #1;
    m_mtime  = nxt;
    b1.req_i = 1'b0;
    check("rvalid", b1.rvalid_o, rq);
    if (b1.rvalid_o === 1'b1 && sbq.size() > 0) begin
      rvalid_cnt++;
      e = sbq.pop_front();
      if (e.chk) check(e.name, b1.rdata_o, e.exp);
    end
    check("irq_timer", irq_t1, exp_t);
    check("irq_software", irq_s1, exp_s);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 5'h0, 4'h0, 32'h0);
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string nm);
    sbq.push_back('{1'b1, exp, nm});
    cycle(1'b1, 1'b0, a, 4'h0, 32'h0);
  endtask

  task automatic rd_model(input logic [4:0] a, input string nm);
    logic [31:0] exp;
    case ({a[4:2], 2'b00})
      5'h00:   exp = m_mtime[31:0];
      5'h04:   exp = m_mtime[63:32];
      5'h08:   exp = m_cmp[31:0];
      5'h0C:   exp = m_cmp[63:32];
      5'h10:   exp = {31'b0, m_msip};
      default: exp = 32'h0;
    endcase
    rd(a, exp, nm);
  endtask

  task automatic wr(input logic [4:0] a, input logic [3:0] be, input logic [31:0] wd);
    sbq.push_back('{1'b0, 32'h0, "write"});
    cycle(1'b1, 1'b1, a, be, wd);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    b1.req_i = 1'b0;
    b4.req_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rvalid", b1.rvalid_o, 1'b0);
    check("rst_rdata", b1.rdata_o, 32'h0);
    check("rst_irq_t", irq_t1, 1'b0);
    check("rst_irq_s", irq_s1, 1'b0);
    check("rst4_rvalid", b4.rvalid_o, 1'b0);
    check("rst4_irq_t", irq_t4, 1'b0);
    rst = 1'b0;
    m_mtime = 64'h0;
    m_cmp   = 64'hFFFF_FFFF_FFFF_FFFF;
    m_msip  = 1'b0;
    sbq.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int found_at;
    int base;

    b1.req_i = 1'b0; b1.we_i = 1'b0; b1.addr_i = '0; b1.be_i = '0; b1.wdata_i = '0;
    b4.req_i = 1'b0; b4.we_i = 1'b0; b4.addr_i = '0; b4.be_i = '0; b4.wdata_i = '0;

    // Free-running count, both prescale settings.
    do_reset();
    idle(10);
    rd(5'h00, 32'd10, "mtime_lo_after_10");
    rd(5'h04, 32'd0, "mtime_hi_after_10");
    idle(28);
    for (int k = 0; k < 8; k++) begin
      b4.req_i = 1'b1; b4.we_i = 1'b0; b4.addr_i = 5'h00;
      idle(1);
      check("p4_rvalid", b4.rvalid_o, 1'b1);
      check("p4_mtime_lo", b4.rdata_o, (k < 4) ? 32'd10 : 32'd11);
    end
    b4.req_i = 1'b0;

    // Register access vectors.
    vt.push_back('{1'b0, 5'h08, 4'h0, 32'h0,         32'hFFFF_FFFF, "cmp_lo_rst"});
    vt.push_back('{1'b0, 5'h0C, 4'h0, 32'h0,         32'hFFFF_FFFF, "cmp_hi_rst"});
    vt.push_back('{1'b0, 5'h10, 4'h0, 32'h0,         32'h0,         "msip_rst"});
    vt.push_back('{1'b0, 5'h14, 4'h0, 32'h0,         32'h0,         "unmapped_14"});
    vt.push_back('{1'b0, 5'h1C, 4'h0, 32'h0,         32'h0,         "unmapped_1c"});
    vt.push_back('{1'b1, 5'h18, 4'hF, 32'hDEAD_BEEF, 32'h0,         "wr_unmapped"});
    vt.push_back('{1'b0, 5'h18, 4'h0, 32'h0,         32'h0,         "unmapped_18"});
    vt.push_back('{1'b1, 5'h08, 4'h3, 32'h1234_5678, 32'h0,         "wr_cmp_lo_be3"});
    vt.push_back('{1'b0, 5'h08, 4'h0, 32'h0,         32'hFFFF_5678, "cmp_lo_be3"});
    vt.push_back('{1'b1, 5'h0C, 4'hC, 32'hAABB_CCDD, 32'h0,         "wr_cmp_hi_bec"});
    vt.push_back('{1'b0, 5'h0C, 4'h0, 32'h0,         32'hAABB_FFFF, "cmp_hi_bec"});
    vt.push_back('{1'b0, 5'h09, 4'h0, 32'h0,         32'hFFFF_5678, "cmp_lo_addr_lsb"});
    vt.push_back('{1'b1, 5'h10, 4'hF, 32'hFFFF_FFFF, 32'h0,         "wr_msip_ones"});
    vt.push_back('{1'b0, 5'h10, 4'h0, 32'h0,         32'h1,         "msip_set"});
    vt.push_back('{1'b1, 5'h10, 4'h2, 32'h0,         32'h0,         "wr_msip_be2"});
    vt.push_back('{1'b0, 5'h10, 4'h0, 32'h0,         32'h1,         "msip_be2_kept"});
    vt.push_back('{1'b1, 5'h10, 4'hF, 32'h0,         32'h0,         "wr_msip_zero"});
    vt.push_back('{1'b0, 5'h10, 4'h0, 32'h0,         32'h0,         "msip_clr"});
    for (int i = 0; i < vt.size(); i++) begin
      if (vt[i].we) wr(vt[i].addr, vt[i].be, vt[i].wdata);
      else          rd(vt[i].addr, vt[i].exp, vt[i].name);
    end
    rd_model(5'h00, "mtime_lo_after_table");

    // Timer interrupt rise and fall.
    do_reset();
    wr(5'h0C, 4'hF, 32'h0);
    wr(5'h08, 4'hF, 32'd20);
    found_at = -1;
    for (int i = 0; i < 60; i++) begin
      idle(1);
      if (irq_t1 === 1'b1) begin
        found_at = i;
        break;
      end
    end
    check("irq_rise_cycle", found_at, 18);
    wr(5'h08, 4'hF, 32'd1000);
    check("irq_hold_at_write", irq_t1, 1'b1);
    idle(1);
    check("irq_fall", irq_t1, 1'b0);

    // Carry, wrap and write/tick collisions.
    do_reset();
    wr(5'h04, 4'hF, 32'h0);
    wr(5'h00, 4'hF, 32'hFFFF_FFFE);
    idle(2);
    rd(5'h00, 32'h0, "carry_lo");
    rd(5'h04, 32'h1, "carry_hi");
    wr(5'h04, 4'hF, 32'hFFFF_FFFF);
    wr(5'h00, 4'hF, 32'hFFFF_FFFF);
    rd(5'h00, 32'hFFFF_FFFF, "wrap_lo_pre");
    rd(5'h04, 32'h0, "wrap_hi");
    rd(5'h00, 32'h1, "wrap_lo_post");
    wr(5'h00, 4'h1, 32'h0000_00AA);
    rd(5'h00, 32'h0000_00AA, "partial_lo");
    rd(5'h04, 32'h0, "partial_lo_no_carry");
    wr(5'h04, 4'h8, 32'h5A00_0000);
    rd(5'h00, 32'h0000_00AC, "hi_wr_lo_frozen");
    rd(5'h04, 32'h5A00_0000, "partial_hi");

    // Back-to-back reads.
    base = rvalid_cnt;
    rd_model(5'h00, "b2b_lo");
    rd_model(5'h04, "b2b_hi");
    rd(5'h14, 32'h0, "b2b_unmapped");
    idle(1);
    check("b2b_rvalid_count", rvalid_cnt - base, 3);

    // Reset asserted while the second of two reads is in flight.
    wr(5'h10, 4'hF, 32'h1);
    wr(5'h08, 4'hF, 32'd5);
    rd_model(5'h00, "pre_rst_lo");
    b1.req_i = 1'b1; b1.we_i = 1'b0; b1.addr_i = 5'h04;
    rst = 1'b1;
    @(posedge clk); #1;
    b1.req_i = 1'b0;
    check("rst_mid_rvalid", b1.rvalid_o, 1'b0);
    check("rst_mid_rdata", b1.rdata_o, 32'h0);
    check("rst_mid_irq_s", irq_s1, 1'b0);
    check("rst_mid_irq_t", irq_t1, 1'b0);
    rst = 1'b0;
    m_mtime = 64'h0;
    m_cmp   = 64'hFFFF_FFFF_FFFF_FFFF;
    m_msip  = 1'b0;
    rd(5'h04, 32'h0, "rst_mid_mtime_hi");
    rd(5'h08, 32'hFFFF_FFFF, "rst_mid_cmp_lo");
    rd(5'h0C, 32'hFFFF_FFFF, "rst_mid_cmp_hi");
    rd(5'h10, 32'h0, "rst_mid_msip");
    rd(5'h00, 32'd4, "rst_mid_mtime_lo");
    idle(1);
    check("sb_empty", sbq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/machine_timer.md
Name: machine_timer

Overview:
- Memory-mapped machine timer and software-interrupt source (CLINT-lite). It is the interrupt-producing end of the core's interrupt interface.
- Keeps a free-running 64-bit mtime counter, a 64-bit mtimecmp, and an msip bit.
- Drives irq_timer_o / irq_software_o into the core's irq_timer_i / irq_software_i inputs.
- Attached to the data bus through a simple single-outstanding request/response port.

Parameters:
- PRESCALE, 1, mtime increments once every PRESCALE clk_i cycles. Legal range 1..65535.
- ADDR_W, 5, byte-address width of the register window.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- req_i  in  1  bus request, single-cycle pulse per access
- we_i  in  1  1 = write, 0 = read
- addr_i  in  ADDR_W  byte address; bits [1:0] ignored
- be_i  in  4  byte enables for writes
- wdata_i  in  32  write data
- gnt_o  out  1  request accepted; combinational, equals req_i (always ready)
- rvalid_o  out  1  response valid one cycle after an accepted request, for reads and writes
- rdata_o  out  32  read data, valid when rvalid_o=1
- irq_timer_o  out  1  machine timer interrupt, level
- irq_software_o  out  1  machine software interrupt, level

Behaviour:
- Single clock. Reset is synchronous and active-high: rst_i sampled on the clk_i rising edge.
- Register map (word offset):
  - 0x00 MTIME_LO
  - 0x04 MTIME_HI
  - 0x08 MTIMECMP_LO
  - 0x0C MTIMECMP_HI
  - 0x10 MSIP: bit0 RW, bits[31:1] read 0
  - all other offsets read 0, writes ignored, rvalid_o still asserted
- Reset values:
  - mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, msip=0, prescaler=0
  - rvalid_o=0, rdata_o=0, irq_timer_o=0, irq_software_o=0
- Prescaler:
  - Counter 0..PRESCALE-1. tick=1 when counter==PRESCALE-1, then counter wraps to 0.
  - For PRESCALE=1, tick=1 every cycle.
  - On tick, mtime <= mtime+1, 64-bit, wrapping from all-ones to 0.
- Writes:
  - Honour be_i per byte and take effect at the clock edge of the accepted request.
  - Register writes do not reset the prescaler.
- Write/tick collision on MTIME_LO or MTIME_HI in the same cycle:
  - The written half takes the written bytes; unwritten bytes of that half keep the pre-increment value.
  - The other half keeps its pre-increment value (no increment, no carry that cycle).
- Reads:
  - 1-cycle latency: rdata_o registered and returns the value before any same-cycle update.
  - rdata_o holds its last value when rvalid_o=0.
- irq_software_o: registered copy of msip, so it rises 1 cycle after the MSIP write edge.
- irq_timer_o:
  - Registered: irq_timer_o <= (mtime >= mtimecmp), unsigned 64-bit, evaluated on current register values.
  - Lags mtime/mtimecmp by one cycle.
  - Level; stays high until mtimecmp is raised above mtime or mtime wraps.
- Bus:
  - req_i every cycle is legal (back-to-back); each accepted request produces exactly one rvalid_o pulse next cycle.
- Reset mid-operation: a pending response is dropped, rvalid_o=0 next cycle, and all state returns to reset values.

Decomposition:
- Into csr_pkg or a new soc_pkg:
  - register offset localparams: MTIMER_MTIME_LO, MTIMER_MTIME_HI, MTIMER_MTIMECMP_LO, MTIMER_MTIMECMP_HI, MTIMER_MSIP
  - MTIMECMP_RST constant
- One natural sub-module: prescaler_tick (parameterised PRESCALE, outputs tick).
- Everything else stays in machine_timer.

Test Plan:
- Reset, PRESCALE=1, run 10 cycles, read MTIME_LO -> rdata_o=10 ±1 per read timing; MTIME_HI=0; irq_timer_o=0 throughout.
- PRESCALE=4, reset, idle 40 cycles, read MTIME_LO -> 10; mtime changes only every 4th cycle.
- Write MTIMECMP_HI=0, then MTIMECMP_LO=20, PRESCALE=1 -> irq_timer_o rises exactly 1 cycle after mtime reaches 20. Then write MTIMECMP_LO=1000 -> irq_timer_o falls 1 cycle after the write edge.
- Write MTIME_LO=32'hFFFF_FFFE, MTIME_HI=0, PRESCALE=1 -> after 2 ticks MTIME_HI=1, MTIME_LO=0 (carry). Separately, write MTIME_HI=32'hFFFF_FFFF and MTIME_LO=32'hFFFF_FFFF -> after next tick mtime=0.
- Write MSIP=32'hFFFF_FFFF -> read returns 1, irq_software_o=1 one cycle after write. Write be_i=4'b0010 data 0 -> msip unchanged. Write MSIP=0 -> irq_software_o=0.
- Back-to-back reads of offsets 0x00,0x04,0x14 on consecutive cycles -> three consecutive rvalid_o pulses, 0x14 returns 0. Assert rst_i during the second -> rvalid_o=0 the next cycle, all registers back to reset values.
